// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parameterised register bank.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned ZERO_IDX  = 0;

  // Address width for a bank of the given depth; never narrower than 1 bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Read/write bus of the register bank: decode drives reads, writeback drives the write port.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned NUM_RD = 2
);
  localparam int unsigned AW = addr_width(DEPTH);

  logic                    we;
  logic [AW-1:0]           waddr;
  logic [WIDTH-1:0]        wdata;
  logic [NUM_RD-1:0]       rd_en;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_valid;
  logic [NUM_RD-1:0]       rd_err;
  logic                    wr_err;

  modport master (
    output we, waddr, wdata, rd_en, rd_addr,
    input  rd_data, rd_valid, rd_err, wr_err
  );

  modport slave (
    input  we, waddr, wdata, rd_en, rd_addr,
    output rd_data, rd_valid, rd_err, wr_err
  );

endinterface

// File: rtl/regfile_rd_port.sv
// One read port: DEPTH:1 select, range check, zero register, write-first bypass,
// optional output register.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          REG_OUT  = 1'b0,
  localparam int unsigned AW      = addr_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [AW-1:0]          addr,
  input  logic [DEPTH*WIDTH-1:0] mem_flat,
  input  logic                   wr_ok,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       data,
  output logic                   valid,
  output logic                   err
);

  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic             in_range;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] g_data;
  logic             g_err;
  logic [WIDTH-1:0] q_data;
  logic             q_err;
  logic             q_valid;

  assign in_range = ({1'b0, addr} < DEPTH_W);

  // Storage select; an out-of-range address matches no entry and yields zero.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (addr == i[AW-1:0]) sel = mem_flat[i*WIDTH +: WIDTH];
    end
  end

  // Raw read value with range, zero-register and bypass priority.
  always_comb begin
    raw = '0;
    if (!in_range) begin
      raw = '0;
    end else if (ZERO_REG && addr == ZERO_IDX[AW-1:0]) begin
      raw = '0;
    end else if (wr_ok && waddr == addr) begin
      raw = wdata;
    end else begin
      raw = sel;
    end
  end

  assign g_data = en ? raw : '0;
  assign g_err  = en && !in_range;

  // Output capture register; only selected onto the outputs when REG_OUT is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_data  <= '0;
      q_err   <= 1'b0;
      q_valid <= 1'b0;
    end else begin
      q_data  <= g_data;
      q_err   <= g_err;
      q_valid <= en;
    end
  end

  assign data  = REG_OUT ? q_data  : g_data;
  assign err   = REG_OUT ? q_err   : g_err;
  assign valid = REG_OUT ? q_valid : en;

endmodule

// File: rtl/regfile_bank.sv
// Parameterised register bank: DEPTH x WIDTH storage, one write port,
// NUM_RD read ports with write-first bypass and out-of-range flagging.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          REG_OUT  = 1'b0
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);

  localparam int unsigned AW      = addr_width(DEPTH);
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH*WIDTH-1:0] mem_flat;
  logic                   wr_in_range;
  logic                   wr_ok;
  logic                   wr_err_q;

  logic [WIDTH-1:0] data_w  [NUM_RD];
  logic             valid_w [NUM_RD];
  logic             err_w   [NUM_RD];

  assign wr_in_range = ({1'b0, bus.waddr} < DEPTH_W);
  assign wr_ok       = bus.we && wr_in_range &&
                       !(ZERO_REG && bus.waddr == ZERO_IDX[AW-1:0]);

  // Storage: per-entry write enables so an illegal address touches nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_ok && bus.waddr == i[AW-1:0]) mem[i] <= bus.wdata;
      end
    end
  end

  // Dropped-write flag for the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) wr_err_q <= 1'b0;
    else     wr_err_q <= bus.we && !wr_in_range;
  end

  assign bus.wr_err = wr_err_q;

  // Flatten storage so each read port sees the whole bank.
  always_comb begin
    mem_flat = '0;
    for (int unsigned i = 0; i < DEPTH; i++) mem_flat[i*WIDTH +: WIDTH] = mem[i];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .REG_OUT  (REG_OUT)
    ) u_port (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.rd_en[p]),
      .addr     (bus.rd_addr[p*AW +: AW]),
      .mem_flat (mem_flat),
      .wr_ok    (wr_ok),
      .waddr    (bus.waddr),
      .wdata    (bus.wdata),
      .data     (data_w[p]),
      .valid    (valid_w[p]),
      .err      (err_w[p])
    );
  end

  // Pack per-port results onto the bus vectors.
  always_comb begin
    bus.rd_data  = '0;
    bus.rd_valid = '0;
    bus.rd_err   = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      bus.rd_data[p*WIDTH +: WIDTH] = data_w[p];
      bus.rd_valid[p]               = valid_w[p];
      bus.rd_err[p]                 = err_w[p];
    end
  end

endmodule

// File: tb/tb_regfile_bank.sv
// Bench for regfile_bank: two builds driven with identical stimulus,
// (A) DEPTH=16, ZERO_REG=1, combinational read and (B) DEPTH=12, ZERO_REG=0,
// registered read, each compared against an array model every cycle.
module tb_regfile_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0;
  logic [3:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic [1:0] rd_en = '0;
  logic [7:0] rd_addr = '0;
  bit         chk_en = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_if #(.WIDTH(32), .DEPTH(16), .NUM_RD(2)) ifa ();
  regfile_if #(.WIDTH(32), .DEPTH(12), .NUM_RD(2)) ifb ();

  assign ifa.we = we;       assign ifb.we = we;
  assign ifa.waddr = waddr; assign ifb.waddr = waddr;
  assign ifa.wdata = wdata; assign ifb.wdata = wdata;
  assign ifa.rd_en = rd_en; assign ifb.rd_en = rd_en;
  assign ifa.rd_addr = rd_addr; assign ifb.rd_addr = rd_addr;

  regfile_bank #(.WIDTH(32), .DEPTH(16), .NUM_RD(2), .ZERO_REG(1'b1), .REG_OUT(1'b0))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  regfile_bank #(.WIDTH(32), .DEPTH(12), .NUM_RD(2), .ZERO_REG(1'b0), .REG_OUT(1'b1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // ---------------- behavioural model ----------------
  int unsigned depth_m [2] = '{16, 12};
  bit          zr_m    [2] = '{1'b1, 1'b0};
  logic [31:0] mem_m   [2][16];
  logic [31:0] qd [2];
  logic        qe [2];
  logic        qv [2];
  logic        ewr [2];

  function automatic bit legal(int d);
    return we && (waddr < depth_m[d]) && !(zr_m[d] && waddr == 0);
  endfunction

  function automatic logic [31:0] model_read(int d, int unsigned a);
    if (a >= depth_m[d]) return 32'h0;
    if (zr_m[d] && a == 0) return 32'h0;
    if (legal(d) && waddr == a) return wdata;
    return mem_m[d][a];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) mem_m[d][i] = '0;
      qd[d] = '0; qe[d] = 1'b0; qv[d] = 1'b0; ewr[d] = 1'b0;
    end
  end

  // Compare DUT outputs against the model, then advance the model over the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (chk_en) begin
        for (int p = 0; p < 2; p++) begin
          int unsigned a;
          a = rd_addr[p*4 +: 4];
          check($sformatf("A.data%0d", p), ifa.rd_data[p*32 +: 32],
                rd_en[p] ? model_read(0, a) : 32'h0);
          check($sformatf("A.err%0d", p), {31'b0, ifa.rd_err[p]},
                {31'b0, rd_en[p] && a >= 16});
          check($sformatf("A.valid%0d", p), {31'b0, ifa.rd_valid[p]}, {31'b0, rd_en[p]});
          check($sformatf("B.data%0d", p), ifb.rd_data[p*32 +: 32], qd[p]);
          check($sformatf("B.err%0d", p), {31'b0, ifb.rd_err[p]}, {31'b0, qe[p]});
          check($sformatf("B.valid%0d", p), {31'b0, ifb.rd_valid[p]}, {31'b0, qv[p]});
        end
        check("A.wr_err", {31'b0, ifa.wr_err}, {31'b0, ewr[0]});
        check("B.wr_err", {31'b0, ifb.wr_err}, {31'b0, ewr[1]});
      end
      for (int p = 0; p < 2; p++) begin
        int unsigned a;
        a = rd_addr[p*4 +: 4];
        qd[p] = (rst || !rd_en[p]) ? 32'h0 : model_read(1, a);
        qe[p] = !rst && rd_en[p] && a >= 12;
        qv[p] = !rst && rd_en[p];
      end
      for (int d = 0; d < 2; d++) ewr[d] = !rst && we && waddr >= depth_m[d];
      if (rst) begin
        for (int d = 0; d < 2; d++)
          for (int i = 0; i < 16; i++) mem_m[d][i] = '0;
      end else begin
        for (int d = 0; d < 2; d++)
          if (legal(d)) mem_m[d][waddr] = wdata;
      end
    end
  end

  task automatic idle();
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; rd_en = '0; rd_addr = '0;
  endtask

  // ---------------- stimulus with literal expectations ----------------
  initial begin
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); chk_en = 1'b1; idle();

    // After reset every address reads zero on both ports.
    for (int a = 0; a < 16; a++) begin
      @(negedge clk); rd_en = 2'b11; rd_addr = {a[3:0], a[3:0]};
      #1;
      check("lit.reset_rd", ifa.rd_data[31:0], 32'h0);
      check("lit.reset_rd1", ifa.rd_data[63:32], 32'h0);
      check("lit.reset_err", {30'b0, ifa.rd_err}, 32'h0);
    end

    // Write r5, read back on both ports.
    @(negedge clk); idle(); we = 1'b1; waddr = 4'd5; wdata = 32'hDEADBEEF;
    @(negedge clk); idle(); rd_en = 2'b11; rd_addr = {4'd5, 4'd5};
    #1;
    check("lit.r5_a0", ifa.rd_data[31:0], 32'hDEADBEEF);
    check("lit.r5_a1", ifa.rd_data[63:32], 32'hDEADBEEF);
    check("lit.r5_b_notyet", {30'b0, ifb.rd_valid}, 32'h0);
    @(negedge clk); idle();
    #1;
    check("lit.r5_b0", ifb.rd_data[31:0], 32'hDEADBEEF);
    check("lit.r5_b1", ifb.rd_data[63:32], 32'hDEADBEEF);
    check("lit.r5_bvalid", {30'b0, ifb.rd_valid}, 32'h3);

    // Write-first bypass on r7.
    @(negedge clk); idle(); we = 1'b1; waddr = 4'd7; wdata = 32'h12345678;
    rd_en = 2'b01; rd_addr = {4'd0, 4'd7};
    #1;
    check("lit.bypass_a", ifa.rd_data[31:0], 32'h12345678);
    @(negedge clk); idle(); rd_en = 2'b10; rd_addr = {4'd7, 4'd0};
    #1;
    check("lit.bypass_b", ifb.rd_data[31:0], 32'h12345678);
    check("lit.r7_held_a", ifa.rd_data[63:32], 32'h12345678);

    // Register 0: hardwired zero in A, ordinary in B.
    @(negedge clk); idle(); we = 1'b1; waddr = 4'd0; wdata = 32'hFFFFFFFF;
    @(negedge clk); idle(); rd_en = 2'b01; rd_addr = 8'h00;
    #1;
    check("lit.zero_a", ifa.rd_data[31:0], 32'h0);
    @(negedge clk); idle();
    #1;
    check("lit.zero_b", ifb.rd_data[31:0], 32'hFFFFFFFF);

    // Address 13: legal in A, dropped in B; address 14 out of range in B.
    @(negedge clk); idle(); we = 1'b1; waddr = 4'd13; wdata = 32'hCAFEF00D;
    @(negedge clk); idle(); rd_en = 2'b11; rd_addr = {4'd13, 4'd14};
    #1;
    check("lit.wr_err_b", {31'b0, ifb.wr_err}, 32'h1);
    check("lit.wr_err_a", {31'b0, ifa.wr_err}, 32'h0);
    check("lit.r13_a", ifa.rd_data[63:32], 32'hCAFEF00D);
    @(negedge clk); idle();
    #1;
    check("lit.oor_b_data", ifb.rd_data, 64'h0);
    check("lit.oor_b_err", {30'b0, ifb.rd_err}, 32'h3);
    check("lit.wr_err_b_clr", {31'b0, ifb.wr_err}, 32'h0);

    // Reset overrides a simultaneous write.
    @(negedge clk); idle(); we = 1'b1; waddr = 4'd3; wdata = 32'hA5A5A5A5;
    @(negedge clk); idle(); rst = 1'b1; we = 1'b1; waddr = 4'd3; wdata = 32'h11111111;
    @(negedge clk); idle(); rd_en = 2'b11; rd_addr = {4'd5, 4'd3};
    #1;
    check("lit.rst_r3_a", ifa.rd_data[31:0], 32'h0);
    check("lit.rst_r5_a", ifa.rd_data[63:32], 32'h0);
    check("lit.rst_b_out", ifb.rd_data, 64'h0);
    check("lit.rst_wr_err", {30'b0, ifa.wr_err, ifb.wr_err}, 32'h0);
    @(negedge clk); idle();
    #1;
    check("lit.rst_r3_b", ifb.rd_data, 64'h0);
    check("lit.rst_bvalid", {30'b0, ifb.rd_valid}, 32'h3);

    // Randomised traffic with occasional reset.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 59) == 0);
      we      = $urandom_range(0, 3) != 0;
      waddr   = 4'($urandom_range(0, 15));
      wdata   = $urandom;
      rd_en   = rst ? 2'b00 : 2'($urandom_range(0, 3));
      rd_addr = 8'($urandom_range(0, 255));
    end
    @(negedge clk); idle();
    @(negedge clk);
    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_bank.md
# regfile_bank

Parameterised register bank: generalises the fixed 16:1, 32-bit register read select to DEPTH registers of WIDTH bits, NUM_RD independent read ports and one write port. Owns the storage, write-first bypass, optional registered read outputs and out-of-range address flagging. Sits in the decode stage between instruction decode (read addresses) and writeback (write port).

## Interface
- WIDTH, 32, data width per register
- DEPTH, 16, number of registers (≥2, need not be a power of 2)
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes
- REG_OUT, 0, 0 = combinational read, 1 = registered read (1-cycle latency)
- AW (localparam), $clog2(DEPTH), address width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- rd_en  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD*AW  read addresses, port p at [p*AW +: AW]
- rd_data  out  NUM_RD*WIDTH  read data, port p at [p*WIDTH +: WIDTH]
- rd_valid  out  NUM_RD  rd_data for port p is valid
- rd_err  out  NUM_RD  port p address ≥ DEPTH
- wr_err  out  1  registered: last cycle's write had waddr ≥ DEPTH

## Operation
- Storage: DEPTH × WIDTH registers.
- Write: at edge, if we && waddr < DEPTH && !(ZERO_REG && waddr==0), mem[waddr] ← wdata. Otherwise storage unchanged.
- wr_err ← we && waddr ≥ DEPTH each edge; dropped write never modifies storage.
- Read value for port p (raw): rd_addr ≥ DEPTH → 0, rd_err=1; ZERO_REG && addr==0 → 0; write-first bypass: we && waddr==rd_addr && write is legal → wdata; else mem[rd_addr]. Never drives X/Z.
- Ports independent; any number may read the same address in the same cycle.
- rd_en=0: rd_data for that port = 0, rd_err=0, rd_valid=0 (REG_OUT=0), or the registered equivalents next cycle (REG_OUT=1).
- REG_OUT=0: rd_data, rd_err, rd_valid = rd_en combinational same cycle.
- REG_OUT=1: raw values captured at edge; rd_data/rd_err/rd_valid hold captured values until next edge. Bypass uses the write of the capturing cycle.

## Timing
- Reset (rst=1 at edge): all mem entries ← 0; rd_data, rd_valid, rd_err (REG_OUT=1), wr_err ← 0. Reset overrides a simultaneous write and read capture.
- REG_OUT=0 outputs during reset cycle reflect current (pre-clear) storage; value is 0 from the cycle after.
- Write latency: visible through storage the cycle after the edge; visible same cycle via bypass.
- Read latency: 0 cycles (REG_OUT=0), 1 cycle (REG_OUT=1).
- No backpressure; one read per port per cycle, one write per cycle.

## Structure
- Package regfile_pkg: function for address width, constants for zero-register index and default WIDTH/DEPTH.
- Sub-module regfile_rd_port: one read port — DEPTH:1 mux, range check, zero-register, bypass compare, optional output register; instantiated NUM_RD times via generate.
- Top owns storage, write decode and wr_err.

## Test plan
- Reset then read all addresses on every port (DEPTH=16) → rd_data=0, rd_err=0 everywhere.
- Write 0xDEADBEEF to r5, next cycle read r5 on port 0 and 1 → both 0xDEADBEEF; REG_OUT=1 build: valid one cycle after rd_en.
- Same-cycle we=1, waddr=7, wdata=0x12345678 with rd_addr0=7 → rd_data0=0x12345678 (bypass), r7 holds value after.
- ZERO_REG=1: write 0xFFFFFFFF to r0, read r0 → 0; ZERO_REG=0 build → 0xFFFFFFFF.
- DEPTH=12: write to addr 13 → wr_err=1 next cycle, no register changed; read addr 14 → rd_data=0, rd_err=1.
- Write r3=0xA5A5A5A5, then rst=1 together with we=1 to r3 → all registers 0, outputs 0, wr_err=0.
